// File: rtl/cpu_core_pkg.sv
// Shared core package: memory access sizes, LSU FSM states and LSU exception causes.
// No ports; imported by the load/store unit and its alignment helper.
package cpu_core_pkg;

    // Access size encodings, matching func3[1:0] of loads and stores
    typedef enum logic [1:0] {
        BYTE  = 2'b00,
        HWORD = 2'b01,
        WORD  = 2'b10,
        DWORD = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } lsu_state_e;

    typedef enum logic [1:0] {
        EXC_LOAD_MISALIGN  = 2'd0,
        EXC_STORE_MISALIGN = 2'd1,
        EXC_LOAD_FAULT     = 2'd2,
        EXC_STORE_FAULT    = 2'd3
    } lsu_exc_cause_e;

    localparam int unsigned IMM_W = 12;
    localparam int unsigned REG_W = 5;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment for the memory port.
// Ports:
//   i_size      access size
//   i_offset    byte offset of the effective address within the bus word
//   i_sign      1 = sign-extend load data, 0 = zero-extend
//   i_rdata     raw bus read data
//   i_wdata     unshifted store data
//   o_be_c      byte enables
//   o_wdata_c   store data shifted onto its byte lanes
//   o_rdata_c   load data shifted down, truncated and extended
module lsu_align
    import cpu_core_pkg::*;
#(
    parameter  int unsigned XLEN   = 32,
    localparam int unsigned NBYTES = XLEN / 8,
    localparam int unsigned OFFW   = $clog2(NBYTES)
) (
    input  mem_size_e          i_size,
    input  logic [OFFW-1:0]    i_offset,
    input  logic               i_sign,
    input  logic [XLEN-1:0]    i_rdata,
    input  logic [XLEN-1:0]    i_wdata,
    output logic [NBYTES-1:0]  o_be_c,
    output logic [XLEN-1:0]    o_wdata_c,
    output logic [XLEN-1:0]    o_rdata_c
);

    logic [XLEN-1:0] w_keep;
    logic [7:0]      w_bmask;
    logic [XLEN-1:0] w_rshift;
    logic            w_sbit;

    // Size masks drive both directions; the read side shifts down, the write side up
    always_comb begin
        w_keep  = '1;
        w_bmask = 8'hFF;
        case (i_size)
            BYTE:    begin w_keep = XLEN'(8'hFF);         w_bmask = 8'h01; end
            HWORD:   begin w_keep = XLEN'(16'hFFFF);      w_bmask = 8'h03; end
            WORD:    begin w_keep = XLEN'(32'hFFFF_FFFF); w_bmask = 8'h0F; end
            default: begin w_keep = '1;                   w_bmask = 8'hFF; end
        endcase

        w_rshift = i_rdata >> {i_offset, 3'b000};

        case (i_size)
            BYTE:    w_sbit = w_rshift[7];
            HWORD:   w_sbit = w_rshift[15];
            WORD:    w_sbit = w_rshift[31];
            default: w_sbit = w_rshift[XLEN-1];
        endcase

        o_rdata_c = (w_rshift & w_keep) | ((i_sign && w_sbit) ? ~w_keep : '0);
        o_wdata_c = (i_wdata & w_keep) << {i_offset, 3'b000};
        o_be_c    = NBYTES'(w_bmask) << i_offset;
    end

endmodule

// File: rtl/load_store_unit_hs.sv
// Load/store unit with req/gnt/rvalid memory handshake, pipeline stall,
// lane alignment, misalignment/bus-error exceptions and flush.
// Ports:
//   clock_i, reset_i                 clock, synchronous active-high reset
//   valid_i, is_load_i, is_store_i   issue strobe and operation type
//   func3_i, rs1_i, rs2_i, imm_i     size/extension, base, store data, offset
//   rd_i, flush_i                    load destination, kill in-flight access
//   busy_o                           stall (combinational: state != IDLE)
//   mem_*                            data memory port
//   wb_valid_o, wb_rd_o, wb_data_o   load writeback pulse
//   exc_valid_o, exc_cause_o, exc_addr_o  exception pulse
module load_store_unit_hs
    import cpu_core_pkg::*;
#(
    parameter  int unsigned XLEN   = 32,
    localparam int unsigned NBYTES = XLEN / 8,
    localparam int unsigned OFFW   = $clog2(NBYTES)
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               valid_i,
    input  logic               is_load_i,
    input  logic               is_store_i,
    input  logic [2:0]         func3_i,
    input  logic [XLEN-1:0]    rs1_i,
    input  logic [XLEN-1:0]    rs2_i,
    input  logic [IMM_W-1:0]   imm_i,
    input  logic [REG_W-1:0]   rd_i,
    input  logic               flush_i,
    output logic               busy_o,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [XLEN-1:0]    mem_addr_o,
    output logic [NBYTES-1:0]  mem_be_o,
    output logic [XLEN-1:0]    mem_wdata_o,
    input  logic               mem_gnt_i,
    input  logic               mem_rvalid_i,
    input  logic [XLEN-1:0]    mem_rdata_i,
    input  logic               mem_err_i,
    output logic               wb_valid_o,
    output logic [REG_W-1:0]   wb_rd_o,
    output logic [XLEN-1:0]    wb_data_o,
    output logic               exc_valid_o,
    output logic [1:0]         exc_cause_o,
    output logic [XLEN-1:0]    exc_addr_o
);

    lsu_state_e       r_state;
    lsu_state_e       w_state_nxt;

    logic             r_we;
    mem_size_e        r_size;
    logic [OFFW-1:0]  r_off;
    logic             r_zext;
    logic [REG_W-1:0] r_rd;
    logic [XLEN-1:0]  r_ea;
    logic             r_killed;
    logic [XLEN-1:0]  r_addr;
    logic [NBYTES-1:0] r_be;
    logic [XLEN-1:0]  r_wdata;
    logic             r_wb_valid;
    logic [REG_W-1:0] r_wb_rd;
    logic [XLEN-1:0]  r_wb_data;
    logic             r_exc_valid;
    lsu_exc_cause_e   r_exc_cause;
    logic [XLEN-1:0]  r_exc_addr;

    logic [XLEN-1:0]  w_ea;
    mem_size_e        w_size;
    logic             w_mem_op;
    logic             w_misaligned;
    logic             w_illegal;
    logic             w_fault;
    lsu_exc_cause_e   w_issue_cause;
    mem_size_e        w_al_size;
    logic [OFFW-1:0]  w_al_off;
    logic             w_al_sign;
    logic [NBYTES-1:0] w_be;
    logic [XLEN-1:0]  w_wdata;
    logic [XLEN-1:0]  w_rdata_ext;
    logic             w_drop_resp;

    // Issue-side decode
    assign w_ea     = rs1_i + {{(XLEN-IMM_W){imm_i[IMM_W-1]}}, imm_i};
    assign w_size   = mem_size_e'(func3_i[1:0]);
    assign w_mem_op = valid_i & (is_load_i | is_store_i);

    always_comb begin
        w_misaligned = 1'b0;
        case (w_size)
            BYTE:    w_misaligned = 1'b0;
            HWORD:   w_misaligned = w_ea[0];
            WORD:    w_misaligned = |w_ea[1:0];
            default: w_misaligned = |w_ea[2:0];
        endcase
    end

    // A doubleword on a 32-bit port is a fault; it outranks misalignment
    assign w_illegal = (w_size == DWORD) && (XLEN == 32);
    assign w_fault   = w_misaligned | w_illegal;

    always_comb begin
        w_issue_cause = EXC_LOAD_MISALIGN;
        if (w_illegal) begin
            w_issue_cause = is_store_i ? EXC_STORE_FAULT : EXC_LOAD_FAULT;
        end else begin
            w_issue_cause = is_store_i ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN;
        end
    end

    // One aligner serves both directions: issue fields in IDLE, latched fields otherwise
    assign w_al_size = (r_state == IDLE) ? w_size           : r_size;
    assign w_al_off  = (r_state == IDLE) ? w_ea[OFFW-1:0]   : r_off;
    assign w_al_sign = (r_state == IDLE) ? ~func3_i[2]      : ~r_zext;

    lsu_align #(.XLEN(XLEN)) u_align (
        .i_size    (w_al_size),
        .i_offset  (w_al_off),
        .i_sign    (w_al_sign),
        .i_rdata   (mem_rdata_i),
        .i_wdata   (rs2_i),
        .o_be_c    (w_be),
        .o_wdata_c (w_wdata),
        .o_rdata_c (w_rdata_ext)
    );

    // A flush in the same cycle as rvalid still suppresses the response
    assign w_drop_resp = r_killed | flush_i;

    // State register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_mem_op && !w_fault) w_state_nxt = REQ;
            REQ: begin
                if (mem_gnt_i)    w_state_nxt = WAIT;
                else if (flush_i) w_state_nxt = IDLE;
            end
            WAIT: if (mem_rvalid_i) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Access latch, writeback and exception registers
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_we        <= 1'b0;
            r_size      <= BYTE;
            r_off       <= '0;
            r_zext      <= 1'b0;
            r_rd        <= '0;
            r_ea        <= '0;
            r_killed    <= 1'b0;
            r_addr      <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
            r_exc_valid <= 1'b0;
            r_exc_cause <= EXC_LOAD_MISALIGN;
            r_exc_addr  <= '0;
        end else begin
            r_wb_valid  <= 1'b0;
            r_exc_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_mem_op) begin
                        if (w_fault) begin
                            r_exc_valid <= 1'b1;
                            r_exc_cause <= w_issue_cause;
                            r_exc_addr  <= w_ea;
                        end else begin
                            r_we     <= is_store_i;
                            r_size   <= w_size;
                            r_off    <= w_ea[OFFW-1:0];
                            r_zext   <= func3_i[2];
                            r_rd     <= rd_i;
                            r_ea     <= w_ea;
                            r_killed <= 1'b0;
                            r_addr   <= {w_ea[XLEN-1:OFFW], OFFW'(0)};
                            r_be     <= w_be;
                            r_wdata  <= w_wdata;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt_i && flush_i) r_killed <= 1'b1;
                end
                WAIT: begin
                    if (flush_i) r_killed <= 1'b1;
                    if (mem_rvalid_i && !w_drop_resp) begin
                        if (mem_err_i) begin
                            r_exc_valid <= 1'b1;
                            r_exc_cause <= r_we ? EXC_STORE_FAULT : EXC_LOAD_FAULT;
                            r_exc_addr  <= r_ea;
                        end else if (!r_we) begin
                            r_wb_valid <= 1'b1;
                            r_wb_rd    <= r_rd;
                            r_wb_data  <= w_rdata_ext;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o      = (r_state != IDLE);
    assign mem_req_o   = (r_state == REQ);
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_be_o    = r_be;
    assign mem_wdata_o = r_wdata;
    assign wb_valid_o  = r_wb_valid;
    assign wb_rd_o     = r_wb_rd;
    assign wb_data_o   = r_wb_data;
    assign exc_valid_o = r_exc_valid;
    assign exc_cause_o = 2'(r_exc_cause);
    assign exc_addr_o  = r_exc_addr;

endmodule

// File: tb/tb_load_store_unit_hs.sv
// Directed bench for load_store_unit_hs: a 32-bit and a 64-bit instance.
module tb_load_store_unit_hs;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // 32-bit instance signals
    logic        v, ld, st, fl, gnt, rv, err;
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, rdata;
    logic [11:0] imm;
    logic [4:0]  rd;
    logic        busy, req, we, wbv, excv;
    logic [31:0] addr, wdata, wbd, exca;
    logic [3:0]  be;
    logic [4:0]  wbrd;
    logic [1:0]  excc;

    // 64-bit instance signals
    logic        q_v, q_ld, q_st, q_fl, q_gnt, q_rv, q_err;
    logic [2:0]  q_f3;
    logic [63:0] q_rs1, q_rs2, q_rdata;
    logic [11:0] q_imm;
    logic [4:0]  q_rd;
    logic        q_busy, q_req, q_we, q_wbv, q_excv;
    logic [63:0] q_addr, q_wdata, q_wbd, q_exca;
    logic [7:0]  q_be;
    logic [4:0]  q_wbrd;
    logic [1:0]  q_excc;

    int n_vec = 0;
    int n_err = 0;

    load_store_unit_hs #(.XLEN(32)) dut32 (
        .clock_i(clk), .reset_i(rst), .valid_i(v), .is_load_i(ld), .is_store_i(st),
        .func3_i(f3), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm), .rd_i(rd), .flush_i(fl),
        .busy_o(busy), .mem_req_o(req), .mem_we_o(we), .mem_addr_o(addr), .mem_be_o(be),
        .mem_wdata_o(wdata), .mem_gnt_i(gnt), .mem_rvalid_i(rv), .mem_rdata_i(rdata),
        .mem_err_i(err), .wb_valid_o(wbv), .wb_rd_o(wbrd), .wb_data_o(wbd),
        .exc_valid_o(excv), .exc_cause_o(excc), .exc_addr_o(exca)
    );

    load_store_unit_hs #(.XLEN(64)) dut64 (
        .clock_i(clk), .reset_i(rst), .valid_i(q_v), .is_load_i(q_ld), .is_store_i(q_st),
        .func3_i(q_f3), .rs1_i(q_rs1), .rs2_i(q_rs2), .imm_i(q_imm), .rd_i(q_rd), .flush_i(q_fl),
        .busy_o(q_busy), .mem_req_o(q_req), .mem_we_o(q_we), .mem_addr_o(q_addr), .mem_be_o(q_be),
        .mem_wdata_o(q_wdata), .mem_gnt_i(q_gnt), .mem_rvalid_i(q_rv), .mem_rdata_i(q_rdata),
        .mem_err_i(q_err), .wb_valid_o(q_wbv), .wb_rd_o(q_wbrd), .wb_data_o(q_wbd),
        .exc_valid_o(q_excv), .exc_cause_o(q_excc), .exc_addr_o(q_exca)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Step to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue32(input logic l, input logic s, input logic [2:0] f,
                           input logic [31:0] a, input logic [11:0] im, input logic [4:0] r);
        v = 1'b1; ld = l; st = s; f3 = f; rs1 = a; imm = im; rd = r;
    endtask

    // Issue a load, grant immediately, return data next cycle; ends in the writeback cycle
    task automatic run_load32(input logic [2:0] f, input logic [31:0] a, input logic [11:0] im,
                              input logic [4:0] r, input logic [31:0] d);
        issue32(1'b1, 1'b0, f, a, im, r);
        tick(); v = 1'b0; gnt = 1'b1;
        tick(); gnt = 1'b0; rv = 1'b1; rdata = d;
        tick(); rv = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        v = 0; ld = 0; st = 0; fl = 0; gnt = 0; rv = 0; err = 0;
        f3 = 0; rs1 = 0; rs2 = 0; rdata = 0; imm = 0; rd = 0;
        q_v = 0; q_ld = 0; q_st = 0; q_fl = 0; q_gnt = 0; q_rv = 0; q_err = 0;
        q_f3 = 0; q_rs1 = 0; q_rs2 = 0; q_rdata = 0; q_imm = 0; q_rd = 0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_busy",  64'(busy),  64'h0);
        check("rst_req",   64'(req),   64'h0);
        check("rst_addr",  64'(addr),  64'h0);
        check("rst_be",    64'(be),    64'h0);
        check("rst_wbd",   64'(wbd),   64'h0);
        check("rst_excv",  64'(excv),  64'h0);
        check("rst_q_be",  64'(q_be),  64'h0);

        // LB at 0x1003, immediate grant
        issue32(1'b1, 1'b0, 3'b000, 32'h1000, 12'h003, 5'd5);
        check("lb_busy_issue", 64'(busy), 64'h0);
        tick(); v = 1'b0;
        check("lb_req",  64'(req),  64'h1);
        check("lb_addr", 64'(addr), 64'h1000);
        check("lb_be",   64'(be),   64'h8);
        check("lb_we",   64'(we),   64'h0);
        gnt = 1'b1;
        tick(); gnt = 1'b0;
        check("lb_req_drop", 64'(req),  64'h0);
        check("lb_busy_wait", 64'(busy), 64'h1);
        rv = 1'b1; rdata = 32'h80FF_FF12;
        tick(); rv = 1'b0;
        check("lb_wbv",  64'(wbv),  64'h1);
        check("lb_wbd",  64'(wbd),  64'hFFFF_FF80);
        check("lb_wbrd", 64'(wbrd), 64'd5);
        check("lb_busy_wb", 64'(busy), 64'h0);
        tick();
        check("lb_wbv_pulse", 64'(wbv), 64'h0);

        // LBU and LH extension cases
        run_load32(3'b100, 32'h1000, 12'h003, 5'd6, 32'h80FF_FF12);
        check("lbu_wbd", 64'(wbd), 64'h0000_0080);
        run_load32(3'b001, 32'h2004, 12'hFFE, 5'd7, 32'h8001_1234);
        check("lh_wbd",  64'(wbd), 64'hFFFF_8001);
        check("lh_wbrd", 64'(wbrd), 64'd7);

        // SH with grant held off 4 cycles; a new issue meanwhile is ignored
        rs2 = 32'h1234_ABCD;
        issue32(1'b0, 1'b1, 3'b001, 32'h2000, 12'h002, 5'd0);
        tick();
        issue32(1'b1, 1'b0, 3'b010, 32'h5000, 12'h000, 5'd9);
        for (int i = 0; i < 4; i++) begin
            check("sh_req",   64'(req),   64'h1);
            check("sh_we",    64'(we),    64'h1);
            check("sh_addr",  64'(addr),  64'h2000);
            check("sh_be",    64'(be),    64'hC);
            check("sh_wdata", 64'(wdata), 64'hABCD_0000);
            check("sh_busy",  64'(busy),  64'h1);
            tick();
        end
        v = 1'b0;
        check("sh_req_held", 64'(req), 64'h1);
        gnt = 1'b1;
        tick(); gnt = 1'b0; rv = 1'b1; rdata = 32'h0;
        tick(); rv = 1'b0;
        check("sh_no_wb",  64'(wbv),  64'h0);
        check("sh_no_exc", 64'(excv), 64'h0);
        check("sh_idle",   64'(busy), 64'h0);

        // Misaligned LW
        issue32(1'b1, 1'b0, 3'b010, 32'h1000, 12'h001, 5'd1);
        tick(); v = 1'b0;
        check("lw_mis_excv",  64'(excv), 64'h1);
        check("lw_mis_cause", 64'(excc), 64'd0);
        check("lw_mis_addr",  64'(exca), 64'h1001);
        check("lw_mis_req",   64'(req),  64'h0);
        check("lw_mis_busy",  64'(busy), 64'h0);
        tick();
        check("lw_mis_pulse", 64'(excv), 64'h0);

        // Misaligned SW -> cause 1
        issue32(1'b0, 1'b1, 3'b010, 32'h3000, 12'h002, 5'd0);
        tick(); v = 1'b0;
        check("sw_mis_cause", 64'(excc), 64'd1);
        check("sw_mis_addr",  64'(exca), 64'h3002);

        // LHU at 0x6 with bus error
        issue32(1'b1, 1'b0, 3'b101, 32'h0, 12'h006, 5'd3);
        tick(); v = 1'b0; gnt = 1'b1;
        tick(); gnt = 1'b0; rv = 1'b1; err = 1'b1;
        tick(); rv = 1'b0; err = 1'b0;
        check("lhu_err_excv",  64'(excv), 64'h1);
        check("lhu_err_cause", 64'(excc), 64'd2);
        check("lhu_err_addr",  64'(exca), 64'h6);
        check("lhu_err_nowb",  64'(wbv),  64'h0);

        // Flush during REQ
        issue32(1'b1, 1'b0, 3'b010, 32'h100, 12'h000, 5'd4);
        tick(); v = 1'b0; fl = 1'b1;
        tick(); fl = 1'b0;
        check("flreq_req",  64'(req),  64'h0);
        check("flreq_busy", 64'(busy), 64'h0);
        tick();
        check("flreq_nowb", 64'(wbv), 64'h0);

        // Flush during WAIT
        issue32(1'b1, 1'b0, 3'b010, 32'h100, 12'h000, 5'd4);
        tick(); v = 1'b0; gnt = 1'b1;
        tick(); gnt = 1'b0; fl = 1'b1;
        tick(); fl = 1'b0;
        check("flwait_busy", 64'(busy), 64'h1);
        rv = 1'b1; rdata = 32'h1111_2222;
        tick(); rv = 1'b0;
        check("flwait_idle",  64'(busy), 64'h0);
        check("flwait_nowb",  64'(wbv),  64'h0);
        check("flwait_noexc", 64'(excv), 64'h0);

        // LD on a 32-bit port: fault, no request
        issue32(1'b1, 1'b0, 3'b011, 32'h0, 12'h008, 5'd2);
        tick(); v = 1'b0;
        check("ld32_excv",  64'(excv), 64'h1);
        check("ld32_cause", 64'(excc), 64'd2);
        check("ld32_req",   64'(req),  64'h0);

        // LD on the 64-bit port
        q_v = 1'b1; q_ld = 1'b1; q_f3 = 3'b011; q_rs1 = 64'h0; q_imm = 12'h008; q_rd = 5'd8;
        tick(); q_v = 1'b0;
        check("ld64_req",  64'(q_req),  64'h1);
        check("ld64_addr", q_addr,      64'h8);
        check("ld64_be",   64'(q_be),   64'hFF);
        q_gnt = 1'b1;
        tick(); q_gnt = 1'b0; q_rv = 1'b1; q_rdata = 64'h8123_4567_89AB_CDEF;
        tick(); q_rv = 1'b0;
        check("ld64_wbv", 64'(q_wbv), 64'h1);
        check("ld64_wbd", q_wbd,      64'h8123_4567_89AB_CDEF);

        // LW in the upper word of the 64-bit port, sign-extended
        q_v = 1'b1; q_ld = 1'b1; q_f3 = 3'b010; q_rs1 = 64'h0; q_imm = 12'h004; q_rd = 5'd9;
        tick(); q_v = 1'b0;
        check("lw64_addr", q_addr,    64'h0);
        check("lw64_be",   64'(q_be), 64'hF0);
        q_gnt = 1'b1;
        tick(); q_gnt = 1'b0; q_rv = 1'b1; q_rdata = 64'h8000_0001_0000_0000;
        tick(); q_rv = 1'b0;
        check("lw64_wbd", q_wbd, 64'hFFFF_FFFF_8000_0001);

        // Reset while waiting; a late rvalid is discarded
        issue32(1'b1, 1'b0, 3'b010, 32'h40, 12'h000, 5'd10);
        tick(); v = 1'b0; gnt = 1'b1;
        tick(); gnt = 1'b0; rst = 1'b1;
        tick(); rst = 1'b0;
        check("rstw_busy", 64'(busy), 64'h0);
        check("rstw_req",  64'(req),  64'h0);
        check("rstw_addr", 64'(addr), 64'h0);
        check("rstw_wbd",  64'(wbd),  64'h0);
        rv = 1'b1; rdata = 32'hDEAD_BEEF;
        tick(); rv = 1'b0;
        check("rstw_nowb",  64'(wbv),  64'h0);
        check("rstw_noexc", 64'(excv), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
